control_unit_pipe: RTL
======================

Name: control_unit_pipe

Overview:
- Parametrised successor to the single-cycle control unit.
- Decodes RV32I, plus RV32M when enabled, in the D stage.
- Registers the control bundle into the ID/EX boundary, with stall, flush and bubble insertion.
- Sequences multi-cycle MUL/DIV occupancy of E with a busy FSM that raises a stall request to the hazard unit.

Parameters:
- EN_MEXT, 1: 1 = decode RV32M; 0 = M encodings flagged illegal.
- MUL_LATENCY, 1: cycles a MUL* op occupies E (>=1).
- DIV_LATENCY, 8: cycles a DIV/REM op occupies E (>=1).
- ALUCTRL_W, 5: ALUControl width (>=5 when EN_MEXT=1).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- Op  in  7  instr[6:0]
- funct3  in  3  instr[14:12]
- funct7  in  7  instr[31:25]
- ValidD  in  1  D holds a real instruction
- StallE  in  1  hazard unit holds E
- FlushE  in  1  hazard unit bubbles E
- ImmSrcD  out  3  combinational, to extender in D
- IllegalD  out  1  combinational illegal-encoding flag
- RegWriteE, ALUSrcE, MemWriteE, BranchE, JumpE  out  1 each  registered controls
- ResultSrcE  out  2  00 ALU, 01 mem, 10 PC+4, 11 imm
- MemOpE  out  2  00 byte, 01 half, 10 word
- Funct3E  out  3  branch/load sign select
- ALUControlE  out  ALUCTRL_W  ALU/MDU opcode
- ValidE  out  1  E holds a real instruction
- IllegalE  out  1  registered illegal flag
- BusyE  out  1  MDU occupancy stall request
- MduDoneE  out  1  one-cycle pulse, final MDU cycle

Behaviour:
- Reset (rst=0, async): all E outputs 0, FSM IDLE, counter 0.
- Opcodes: load 0000011, store 0100011, R 0110011, I-ALU 0010011, branch 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
- ImmSrc encoding: 000 I, 001 S, 010 B, 011 J, 100 U.
- ALU codes: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu, 7 sll, 8 srl, 9 sra, 10 passB.
- M codes: 16 mul, 17 mulh, 18 mulhsu, 19 mulhu, 20 div, 21 divu, 22 rem, 23 remu.
- funct7 legality:
  - R-type: 0000000 for any funct3; 0100000 only for sub/sra.
  - 0000001 is M when EN_MEXT=1, else illegal.
  - I-shift: slli needs funct7=0000000; srli/srai need 0000000/0100000.
- MemOp = funct3[1:0] for load/store. funct3 11 on loads/stores, and funct3 010/011 on branches, are illegal.
- An illegal or !ValidD instruction decodes to a bubble: all write/branch/jump enables 0, ValidE=0. IllegalE = IllegalD & ValidD.
- E register update priority per cycle: reset > FlushE > (StallE | BusyE) > load.
  - FlushE: bubble (enables 0, ValidE 0, IllegalE 0).
  - Stall or busy: hold.
- FSM:
  - IDLE -> BUSY when an M op loads into E and its latency L > 1; counter = L-2; BusyE=1.
  - In BUSY, the counter decrements each cycle. At 0: MduDoneE=1 that cycle, next state IDLE, BusyE drops.
  - BusyE is asserted for exactly L-1 cycles after the load edge.
  - L=1: stays IDLE; MduDoneE pulses in the first E cycle.
- FlushE in BUSY: abort. Next state IDLE, counter 0, E bubbled, no MduDoneE.
- StallE in BUSY: counter still decrements (MDU progresses); E holds.
- rst deasserted mid-BUSY restarts in IDLE.
- Latency: D inputs -> E outputs, one clk edge. ImmSrcD/IllegalD are zero-latency.

Decomposition:
- Package rv32_ctrl_pkg: opcode constants, ALU/M code constants, ImmSrc/ResultSrc/MemOp encodings, funct7 constants.
- Sub-module control_decode: purely combinational decoder.
- Top holds the E register and MDU FSM.

Test Plan:
- add x1,x2,x3 (Op 0110011, f3 000, f7 0), ValidD=1 -> next edge: RegWriteE=1, ALUControlE=0, ResultSrcE=00, ValidE=1, BusyE=0.
- lw (0000011, f3 010) -> ImmSrcD=000 immediately; next edge: ALUSrcE=1, ResultSrcE=01, MemOpE=10. Then FlushE=1 -> all enables 0, ValidE=0.
- div (f7 0000001, f3 100), DIV_LATENCY=8 -> ALUControlE=20; BusyE=1 for 7 cycles; MduDoneE pulses on 7th; a new add in D loads on the following edge.
- div, then FlushE at BUSY cycle 3 -> BusyE=0 next cycle, ValidE=0, MduDoneE never pulses.
- EN_MEXT=0 with mul encoding, or funct7 0100000 with f3 111 -> IllegalD=1; next edge IllegalE=1, RegWriteE=0. Also Op 1111111 -> IllegalD=1.
- rst low mid-BUSY -> immediately BusyE=0 and all outputs 0; after release, the first instruction decodes normally.

Source files
------------

// File: rtl/rv32_ctrl_pkg.sv
// Shared encodings for the pipelined RV32I/RV32M control unit: opcodes,
// ALU/MDU operation codes, immediate/result selects and funct7 patterns.
package rv32_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;
    localparam logic [1:0] RES_IMM = 2'b11;

    localparam logic [1:0] MEMOP_B = 2'b00;
    localparam logic [1:0] MEMOP_H = 2'b01;
    localparam logic [1:0] MEMOP_W = 2'b10;

    localparam logic [4:0] ALU_ADD   = 5'd0;
    localparam logic [4:0] ALU_SUB   = 5'd1;
    localparam logic [4:0] ALU_AND   = 5'd2;
    localparam logic [4:0] ALU_OR    = 5'd3;
    localparam logic [4:0] ALU_XOR   = 5'd4;
    localparam logic [4:0] ALU_SLT   = 5'd5;
    localparam logic [4:0] ALU_SLTU  = 5'd6;
    localparam logic [4:0] ALU_SLL   = 5'd7;
    localparam logic [4:0] ALU_SRL   = 5'd8;
    localparam logic [4:0] ALU_SRA   = 5'd9;
    localparam logic [4:0] ALU_PASSB = 5'd10;
    // MDU codes are 16 + funct3: mul, mulh, mulhsu, mulhu, div, divu, rem, remu
    localparam logic [4:0] M_BASE    = 5'd16;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } mdu_state_e;

    // Base-ISA ALU operation selected by funct3 when funct7 carries no variant.
    function automatic logic [4:0] alu_base(input logic [2:0] f3);
        logic [4:0] code;
        case (f3)
            3'b000:  code = ALU_ADD;
            3'b001:  code = ALU_SLL;
            3'b010:  code = ALU_SLT;
            3'b011:  code = ALU_SLTU;
            3'b100:  code = ALU_XOR;
            3'b101:  code = ALU_SRL;
            3'b110:  code = ALU_OR;
            3'b111:  code = ALU_AND;
            default: code = ALU_ADD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/control_decode.sv
// Purely combinational D-stage decoder: instruction fields to control bundle,
// immediate select and an illegal-encoding flag.
module control_decode
    import rv32_ctrl_pkg::*;
#(
    parameter bit EN_MEXT   = 1'b1,
    parameter int ALUCTRL_W = 5
) (
    input  logic [6:0]           op_i,
    input  logic [2:0]           funct3_i,
    input  logic [6:0]           funct7_i,
    output logic [2:0]           imm_src_o,
    output logic                 illegal_o,
    output logic                 reg_write_o,
    output logic                 alu_src_o,
    output logic                 mem_write_o,
    output logic                 branch_o,
    output logic                 jump_o,
    output logic [1:0]           result_src_o,
    output logic [1:0]           mem_op_o,
    output logic [ALUCTRL_W-1:0] alu_ctrl_o,
    output logic                 mdu_o,
    output logic                 mdu_div_o
);

    logic [4:0] alu_s;

    // Opcode/funct decode; a bubble for illegal encodings is applied by the caller.
    always_comb begin
        imm_src_o    = IMM_I;
        illegal_o    = 1'b0;
        reg_write_o  = 1'b0;
        alu_src_o    = 1'b0;
        mem_write_o  = 1'b0;
        branch_o     = 1'b0;
        jump_o       = 1'b0;
        result_src_o = RES_ALU;
        mem_op_o     = MEMOP_B;
        alu_s        = ALU_ADD;
        mdu_o        = 1'b0;
        mdu_div_o    = 1'b0;
        case (op_i)
            OP_LOAD: begin
                reg_write_o  = 1'b1;
                alu_src_o    = 1'b1;
                result_src_o = RES_MEM;
                mem_op_o     = funct3_i[1:0];
                illegal_o    = (funct3_i[1:0] == 2'b11);
            end
            OP_STORE: begin
                imm_src_o   = IMM_S;
                mem_write_o = 1'b1;
                alu_src_o   = 1'b1;
                mem_op_o    = funct3_i[1:0];
                illegal_o   = (funct3_i[1:0] == 2'b11);
            end
            OP_R: begin
                reg_write_o = 1'b1;
                case (funct7_i)
                    F7_BASE: alu_s = alu_base(funct3_i);
                    F7_ALT: begin
                        if (funct3_i == 3'b000) begin
                            alu_s = ALU_SUB;
                        end else if (funct3_i == 3'b101) begin
                            alu_s = ALU_SRA;
                        end else begin
                            illegal_o = 1'b1;
                        end
                    end
                    F7_MEXT: begin
                        if (EN_MEXT) begin
                            alu_s     = M_BASE | {2'b00, funct3_i};
                            mdu_o     = 1'b1;
                            mdu_div_o = funct3_i[2];
                        end else begin
                            illegal_o = 1'b1;
                        end
                    end
                    default: illegal_o = 1'b1;
                endcase
            end
            OP_IALU: begin
                reg_write_o = 1'b1;
                alu_src_o   = 1'b1;
                case (funct3_i)
                    3'b001: begin
                        if (funct7_i == F7_BASE) begin
                            alu_s = ALU_SLL;
                        end else begin
                            illegal_o = 1'b1;
                        end
                    end
                    3'b101: begin
                        if (funct7_i == F7_BASE) begin
                            alu_s = ALU_SRL;
                        end else if (funct7_i == F7_ALT) begin
                            alu_s = ALU_SRA;
                        end else begin
                            illegal_o = 1'b1;
                        end
                    end
                    default: alu_s = alu_base(funct3_i);
                endcase
            end
            OP_BRANCH: begin
                imm_src_o = IMM_B;
                branch_o  = 1'b1;
                alu_s     = ALU_SUB;
                illegal_o = (funct3_i == 3'b010) || (funct3_i == 3'b011);
            end
            OP_JAL: begin
                imm_src_o    = IMM_J;
                jump_o       = 1'b1;
                reg_write_o  = 1'b1;
                result_src_o = RES_PC4;
            end
            OP_JALR: begin
                jump_o       = 1'b1;
                reg_write_o  = 1'b1;
                alu_src_o    = 1'b1;
                result_src_o = RES_PC4;
            end
            OP_LUI: begin
                imm_src_o    = IMM_U;
                reg_write_o  = 1'b1;
                alu_src_o    = 1'b1;
                result_src_o = RES_IMM;
                alu_s        = ALU_PASSB;
            end
            OP_AUIPC: begin
                imm_src_o   = IMM_U;
                reg_write_o = 1'b1;
                alu_src_o   = 1'b1;
            end
            default: illegal_o = 1'b1;
        endcase
    end

    assign alu_ctrl_o = ALUCTRL_W'(alu_s);

endmodule

// File: rtl/control_unit_pipe.sv
// Pipelined control unit: D-stage decode, ID/EX control register with
// stall/flush/bubble, and the MDU occupancy FSM that requests E stalls.
module control_unit_pipe
    import rv32_ctrl_pkg::*;
#(
    parameter bit EN_MEXT     = 1'b1,
    parameter int MUL_LATENCY = 1,
    parameter int DIV_LATENCY = 8,
    parameter int ALUCTRL_W   = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           Op,
    input  logic [2:0]           funct3,
    input  logic [6:0]           funct7,
    input  logic                 ValidD,
    input  logic                 StallE,
    input  logic                 FlushE,
    output logic [2:0]           ImmSrcD,
    output logic                 IllegalD,
    output logic                 RegWriteE,
    output logic                 ALUSrcE,
    output logic                 MemWriteE,
    output logic                 BranchE,
    output logic                 JumpE,
    output logic [1:0]           ResultSrcE,
    output logic [1:0]           MemOpE,
    output logic [2:0]           Funct3E,
    output logic [ALUCTRL_W-1:0] ALUControlE,
    output logic                 ValidE,
    output logic                 IllegalE,
    output logic                 BusyE,
    output logic                 MduDoneE
);

    localparam int LAT_MAX = (MUL_LATENCY > DIV_LATENCY) ? MUL_LATENCY : DIV_LATENCY;
    localparam int CNT_W   = (LAT_MAX > 2) ? $clog2(LAT_MAX) : 1;
    // The counter starts at L-2 so that BUSY lasts L-1 cycles ending at zero.
    localparam logic [CNT_W-1:0] MUL_INIT = CNT_W'((MUL_LATENCY > 1) ? MUL_LATENCY - 2 : 0);
    localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'((DIV_LATENCY > 1) ? DIV_LATENCY - 2 : 0);
    localparam bit LONG_MUL = (MUL_LATENCY > 1);
    localparam bit LONG_DIV = (DIV_LATENCY > 1);

    logic                 reg_write_s, alu_src_s, mem_write_s, branch_s, jump_s;
    logic [1:0]           result_src_s, mem_op_s;
    logic [ALUCTRL_W-1:0] alu_ctrl_s;
    logic                 mdu_s, mdu_div_s, long_op_s, busy_s;

    logic                 reg_write_d, alu_src_d, mem_write_d, branch_d, jump_d;
    logic                 reg_write_q, alu_src_q, mem_write_q, branch_q, jump_q;
    logic [1:0]           result_src_d, mem_op_d, result_src_q, mem_op_q;
    logic [2:0]           funct3_d, funct3_q;
    logic [ALUCTRL_W-1:0] alu_ctrl_d, alu_ctrl_q;
    logic                 valid_d, valid_q, illegal_d, illegal_q, done_d, done_q;
    logic [CNT_W-1:0]     cnt_d, cnt_q;
    mdu_state_e           state_d, state_q;

    control_decode #(
        .EN_MEXT   (EN_MEXT),
        .ALUCTRL_W (ALUCTRL_W)
    ) u_decode (
        .op_i         (Op),
        .funct3_i     (funct3),
        .funct7_i     (funct7),
        .imm_src_o    (ImmSrcD),
        .illegal_o    (IllegalD),
        .reg_write_o  (reg_write_s),
        .alu_src_o    (alu_src_s),
        .mem_write_o  (mem_write_s),
        .branch_o     (branch_s),
        .jump_o       (jump_s),
        .result_src_o (result_src_s),
        .mem_op_o     (mem_op_s),
        .alu_ctrl_o   (alu_ctrl_s),
        .mdu_o        (mdu_s),
        .mdu_div_o    (mdu_div_s)
    );

    assign busy_s    = (state_q == S_BUSY);
    assign long_op_s = mdu_div_s ? LONG_DIV : LONG_MUL;

    // Next-state for the MDU FSM and the E register: flush > stall/busy > load.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        done_d       = 1'b0;
        reg_write_d  = reg_write_q;
        alu_src_d    = alu_src_q;
        mem_write_d  = mem_write_q;
        branch_d     = branch_q;
        jump_d       = jump_q;
        result_src_d = result_src_q;
        mem_op_d     = mem_op_q;
        funct3_d     = funct3_q;
        alu_ctrl_d   = alu_ctrl_q;
        valid_d      = valid_q;
        illegal_d    = illegal_q;

        case (state_q)
            S_BUSY: begin
                if (FlushE) begin
                    state_d = S_IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                end else if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_IDLE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (FlushE || !(StallE || busy_s)) begin
            reg_write_d  = 1'b0;
            alu_src_d    = 1'b0;
            mem_write_d  = 1'b0;
            branch_d     = 1'b0;
            jump_d       = 1'b0;
            result_src_d = RES_ALU;
            mem_op_d     = MEMOP_B;
            funct3_d     = 3'b000;
            alu_ctrl_d   = {ALUCTRL_W{1'b0}};
            valid_d      = 1'b0;
            illegal_d    = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        if (FlushE) begin
            illegal_d = 1'b0;
        end else if (StallE || busy_s) begin
            illegal_d = illegal_q;
        end else if (ValidD && !IllegalD) begin
            reg_write_d  = reg_write_s;
            alu_src_d    = alu_src_s;
            mem_write_d  = mem_write_s;
            branch_d     = branch_s;
            jump_d       = jump_s;
            result_src_d = result_src_s;
            mem_op_d     = mem_op_s;
            funct3_d     = funct3;
            alu_ctrl_d   = alu_ctrl_s;
            valid_d      = 1'b1;
            if (mdu_s && long_op_s) begin
                state_d = S_BUSY;
                cnt_d   = mdu_div_s ? DIV_INIT : MUL_INIT;
            end else if (mdu_s) begin
                done_d = 1'b1;
            end else begin
                done_d = 1'b0;
            end
        end else begin
            illegal_d = IllegalD & ValidD;
        end

        done_d = done_d | ((state_d == S_BUSY) && (cnt_d == {CNT_W{1'b0}}));
    end

    // E-stage control register and MDU FSM state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= {CNT_W{1'b0}};
            done_q       <= 1'b0;
            reg_write_q  <= 1'b0;
            alu_src_q    <= 1'b0;
            mem_write_q  <= 1'b0;
            branch_q     <= 1'b0;
            jump_q       <= 1'b0;
            result_src_q <= 2'b00;
            mem_op_q     <= 2'b00;
            funct3_q     <= 3'b000;
            alu_ctrl_q   <= {ALUCTRL_W{1'b0}};
            valid_q      <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            done_q       <= done_d;
            reg_write_q  <= reg_write_d;
            alu_src_q    <= alu_src_d;
            mem_write_q  <= mem_write_d;
            branch_q     <= branch_d;
            jump_q       <= jump_d;
            result_src_q <= result_src_d;
            mem_op_q     <= mem_op_d;
            funct3_q     <= funct3_d;
            alu_ctrl_q   <= alu_ctrl_d;
            valid_q      <= valid_d;
            illegal_q    <= illegal_d;
        end
    end

    assign RegWriteE   = reg_write_q;
    assign ALUSrcE     = alu_src_q;
    assign MemWriteE   = mem_write_q;
    assign BranchE     = branch_q;
    assign JumpE       = jump_q;
    assign ResultSrcE  = result_src_q;
    assign MemOpE      = mem_op_q;
    assign Funct3E     = funct3_q;
    assign ALUControlE = alu_ctrl_q;
    assign ValidE      = valid_q;
    assign IllegalE    = illegal_q;
    assign BusyE       = busy_s;
    assign MduDoneE    = done_q;

endmodule
